alu_arbiter: RTL and testbench

Round-robin controller that shares the single processor ALU between two requesters: port 0 (execute stage) and port 1 (address-generation / memory stage). It accepts one operation at a time through a valid/ready handshake, drives the ALU's operand, opcode and enable inputs for a fixed number of cycles, captures the result and flags, and returns them to the granted requester through a response handshake. It sits between the pipeline stages and the `ALU` instance, replacing direct stage-to-ALU wiring.

---
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU between two requesters (port 0 = execute stage, port 1 =
// address-generation / memory stage). One operation is in flight at a time.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready [1:0]  per-port request handshake (bit i = port i)
//   req_a0/req_b0/req_op0      port 0 operands and opcode
//   req_a1/req_b1/req_op1      port 1 operands and opcode
//   rsp_valid/rsp_ready [1:0]  per-port response handshake
//   rsp_result/zero/neg        captured ALU result and flags (shared bus)
//   alu_a/alu_b/alu_op/alu_en  drive the ALU instance
//   alu_result/zero/neg        ALU outputs
//   busy                       high whenever the FSM is not idle
//   dbg_state                  current FSM state, for observation only
//
// Handshake rule (both directions): a transfer happens in a cycle where
// valid and ready are both high at the rising edge. Request valid may be
// held for any number of cycles; operands are sampled only at the transfer.
// Response valid, result and flags stay stable until the transfer.
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ALU_LATENCY = 1    // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [2:0]       req_op0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, neg_q, neg_d;
  logic             gnt_sel;

  // A lone valid port wins; when both are valid the round-robin pointer decides.
  assign gnt_sel = (req_valid == 2'b11) ? prio_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    alu_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is masked during reset so nothing appears accepted that cycle.
        if (!reset && (req_valid != 2'b00)) begin
          req_ready = gnt_sel ? 2'b10 : 2'b01;
          gnt_d     = gnt_sel;
          a_d       = gnt_sel ? req_a1  : req_a0;
          b_d       = gnt_sel ? req_b1  : req_b0;
          op_d      = gnt_sel ? req_op1 : req_op0;
          cnt_d     = LAT;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        alu_en = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        // Only the last EXEC cycle's ALU output is taken.
        if (cnt_q == 4'd1) begin
          res_d   = alu_result;
          zero_d  = alu_zero;
          neg_d   = alu_neg;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          prio_d  = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'd0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_neg    = neg_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checks every cycle of the
// latency-1 instance; directed tasks pin literal results; a second instance
// with latency 3 checks the sampling point of the ALU output.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int L1 = 1;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (latency 1) ----------------
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready, dbg_state;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1, rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]   req_op0, req_op1, alu_op;
  logic         rsp_zero, rsp_neg, alu_en, alu_zero, alu_neg, busy;

  alu_arbiter #(.WIDTH(W), .ALU_LATENCY(L1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_en(alu_en),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- DUT (latency 3) ----------------
  logic [1:0]   t3_req_valid, t3_req_ready, t3_rsp_valid, t3_rsp_ready, t3_dbg_state;
  logic [W-1:0] t3_req_a0, t3_req_b0, t3_req_a1, t3_req_b1, t3_rsp_result;
  logic [W-1:0] t3_alu_a, t3_alu_b, t3_alu_result;
  logic [2:0]   t3_req_op0, t3_req_op1, t3_alu_op;
  logic         t3_rsp_zero, t3_rsp_neg, t3_alu_en, t3_alu_zero, t3_alu_neg, t3_busy;
  logic         t3_junk;

  alu_arbiter #(.WIDTH(W), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(t3_req_valid), .req_ready(t3_req_ready),
    .req_a0(t3_req_a0), .req_b0(t3_req_b0), .req_op0(t3_req_op0),
    .req_a1(t3_req_a1), .req_b1(t3_req_b1), .req_op1(t3_req_op1),
    .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready),
    .rsp_result(t3_rsp_result), .rsp_zero(t3_rsp_zero), .rsp_neg(t3_rsp_neg),
    .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_op(t3_alu_op), .alu_en(t3_alu_en),
    .alu_result(t3_alu_result), .alu_zero(t3_alu_zero), .alu_neg(t3_alu_neg),
    .busy(t3_busy), .dbg_state(t3_dbg_state)
  );

  // ---------------- ALU environment ----------------
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  assign alu_result    = alu_fn(alu_a, alu_b, alu_op);
  assign alu_zero      = (alu_result == '0);
  assign alu_neg       = alu_result[W-1];
  assign t3_alu_result = t3_junk ? 32'hDEAD_BEEF : alu_fn(t3_alu_a, t3_alu_b, t3_alu_op);
  assign t3_alu_zero   = (t3_alu_result == '0);
  assign t3_alu_neg    = t3_alu_result[W-1];

  // ---------------- scoreboard counters ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s at t=%0t: got no event, required one within the cycle bound", name, $time);
  endtask

  // ---------------- transaction model (latency-1 DUT) ----------------
  // One outstanding operation: accepted at cycle m_start, ALU busy for
  // cycles m_start+1..m_start+L1, response offered from m_start+L1+1 until
  // the granted port takes it.
  bit           chk_en = 1'b0;
  bit           m_out = 1'b0, m_g = 1'b0, m_prio = 1'b0;
  int           m_start = 0, m_cyc = 0, m_k;
  logic [W-1:0] m_la = '0, m_lb = '0, m_prev = '0, m_new;
  logic [2:0]   m_lop = 3'd0;
  logic         m_pz = 1'b0, m_pn = 1'b0;
  bit           m_exec, m_resp, m_gsel;
  logic [1:0]   e_ready, e_rv;

  always @(negedge clk) begin
    m_k    = m_cyc - m_start;
    m_new  = alu_fn(m_la, m_lb, m_lop);
    m_exec = m_out && (m_k >= 1) && (m_k <= L1);
    m_resp = m_out && (m_k > L1);
    m_gsel = (req_valid == 2'b11) ? m_prio : req_valid[1];
    e_ready = (!m_out && !reset && (req_valid != 2'b00)) ? (m_gsel ? 2'b10 : 2'b01) : 2'b00;
    e_rv    = m_resp ? (m_g ? 2'b10 : 2'b01) : 2'b00;
    if (chk_en) begin
      check("model req_ready", req_ready, e_ready);
      check("model rsp_valid", rsp_valid, e_rv);
      check("model alu_en", alu_en, m_exec);
      check("model busy", busy, m_out);
      check("model alu_a", alu_a, m_la);
      check("model alu_b", alu_b, m_lb);
      check("model alu_op", alu_op, m_lop);
      check("model rsp_result", rsp_result, m_resp ? m_new : m_prev);
      check("model rsp_zero", rsp_zero, m_resp ? (m_new == '0) : m_pz);
      check("model rsp_neg", rsp_neg, m_resp ? m_new[W-1] : m_pn);
    end
    if (reset) begin
      m_out = 1'b0; m_prio = 1'b0; m_la = '0; m_lb = '0; m_lop = 3'd0;
      m_prev = '0; m_pz = 1'b0; m_pn = 1'b0;
    end else if (!m_out && (req_valid != 2'b00)) begin
      m_out = 1'b1; m_g = m_gsel; m_start = m_cyc;
      m_la  = m_gsel ? req_a1  : req_a0;
      m_lb  = m_gsel ? req_b1  : req_b0;
      m_lop = m_gsel ? req_op1 : req_op0;
    end else if (m_resp && rsp_ready[m_g]) begin
      m_out = 1'b0; m_prio = !m_g;
      m_prev = m_new; m_pz = (m_new == '0); m_pn = m_new[W-1];
    end
    m_cyc++;
  end

  // ---------------- driver tasks ----------------
  // Called and returns at posedge+1. Issues one request on port p, checks
  // the response against literal expectations, holds rsp_ready low for
  // `hold` extra cycles (raising the other port's rsp_ready meanwhile), or
  // with pre_ready keeps rsp_ready high from the start.
  task automatic run_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] exp_res,
                        input logic exp_z, input logic exp_n, input int hold,
                        input bit pre_ready, output int acc_cyc, output int rsp_cyc,
                        output int en_cnt);
    int t;
    bit got;
    logic [1:0] pm;
    pm = (p == 1) ? 2'b10 : 2'b01;
    if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
    else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    req_valid[p] = 1'b1;
    if (pre_ready) rsp_ready[p] = 1'b1;
    t = 0; got = 1'b0; acc_cyc = 0; rsp_cyc = 0; en_cnt = 0;
    while (!got && t < 40) begin
      @(negedge clk);
      if (req_ready[p]) got = 1'b1;
      else begin @(posedge clk); #1; t++; end
    end
    if (!got) begin
      fail_timeout($sformatf("p%0d accept", p));
      req_valid[p] = 1'b0; rsp_ready[p] = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    rsp_cyc = 1; got = 1'b0;
    while (!got && rsp_cyc < 40) begin
      @(negedge clk);
      if (alu_en) en_cnt++;
      if (rsp_valid[p]) got = 1'b1;
      else begin @(posedge clk); #1; rsp_cyc++; end
    end
    if (!got) begin
      fail_timeout($sformatf("p%0d response", p));
      rsp_ready[p] = 1'b0;
      return;
    end
    check($sformatf("p%0d result", p), rsp_result, exp_res);
    check($sformatf("p%0d zero", p), rsp_zero, exp_z);
    check($sformatf("p%0d neg", p), rsp_neg, exp_n);
    if (pre_ready) begin
      @(posedge clk); #1;
      rsp_ready[p] = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      rsp_ready[1-p] = 1'b1;
      @(negedge clk);
      check("hold rsp_valid", rsp_valid, pm);
      check("hold result", rsp_result, exp_res);
      check("hold zero", rsp_zero, exp_z);
      check("hold neg", rsp_neg, exp_n);
      check("hold req_ready", req_ready, 2'b00);
    end
    @(posedge clk); #1;
    if (hold > 0) rsp_ready[1-p] = 1'b0;
    rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[p] = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: bench still running, required to finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int acc, rc, en, acc0, acc1, rc1, en1, t_drop;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_op0 = 3'd0; req_a1 = '0; req_b1 = '0; req_op1 = 3'd0;
    t3_req_valid = 2'b00; t3_rsp_ready = 2'b00; t3_junk = 1'b0;
    t3_req_a0 = '0; t3_req_b0 = '0; t3_req_op0 = 3'd0;
    t3_req_a1 = '0; t3_req_b1 = '0; t3_req_op1 = 3'd0;

    // Reset cycle with a request pending: nothing may be accepted.
    @(posedge clk); #1;
    chk_en = 1'b1;
    req_valid = 2'b01; req_a0 = 32'h55;
    @(negedge clk);
    check("reset req_ready", req_ready, 2'b00);
    check("reset busy", busy, 1'b0);
    check("reset rsp_valid", rsp_valid, 2'b00);
    check("reset alu_en", alu_en, 1'b0);
    check("reset rsp_result", rsp_result, 32'h0);
    check("reset alu_a", alu_a, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00;

    // Port 0 AND: 10 & 20 = 0, zero flag set.
    run_op(0, 32'd10, 32'd20, ALU_AND, 32'd0, 1'b1, 1'b0, 0, 1'b0, acc, rc, en);
    check("and rsp cycle", rc, L1 + 1);
    check("and alu_en cycles", en, 1);

    // Port 1 ADD then SUB.
    run_op(1, 32'd30, 32'd20, ALU_ADD, 32'd50, 1'b0, 1'b0, 0, 1'b0, acc, rc, en);
    check("add alu_en cycles", en, 1);
    run_op(1, 32'hFFF, 32'hF0F, ALU_SUB, 32'hF0, 1'b0, 1'b0, 0, 1'b0, acc, rc, en);
    check("sub alu_en cycles", en, 1);
    check("sub rsp cycle", rc, L1 + 1);

    // Simultaneous requests after reset: port 0 first, then port 1.
    pulse_reset();
    fork
      run_op(0, 32'd20, 32'd30, ALU_SUB, 32'hFFFF_FFF6, 1'b0, 1'b1, 0, 1'b0, acc0, rc, en);
      run_op(1, 32'd1, 32'd1, ALU_ADD, 32'd2, 1'b0, 1'b0, 0, 1'b0, acc1, rc1, en1);
    join
    check("pair1 port0 first", acc0 < acc1, 1'b1);
    fork
      run_op(0, 32'hF0F0, 32'hFF00, ALU_AND, 32'hF000, 1'b0, 1'b0, 0, 1'b0, acc0, rc, en);
      run_op(1, 32'd1, 32'd2, ALU_OR, 32'd3, 1'b0, 1'b0, 0, 1'b0, acc1, rc1, en1);
    join
    check("pair2 port0 first", acc0 < acc1, 1'b1);

    // Response stalled 5 cycles while port 1 waits; port 1 then served.
    req_a1 = 32'd5; req_b1 = 32'd9; req_op1 = ALU_SLT; req_valid[1] = 1'b1;
    run_op(0, 32'h5, 32'hA, ALU_OR, 32'hF, 1'b0, 1'b0, 4, 1'b0, acc0, rc, en);
    run_op(1, 32'd5, 32'd9, ALU_SLT, 32'd1, 1'b0, 1'b0, 0, 1'b0, acc1, rc1, en1);
    check("stall wait grant after", acc1 > acc0 + L1 + 5, 1'b1);

    // rsp_ready high before rsp_valid: idle again at cycle L+2.
    run_op(1, 32'd7, 32'd8, ALU_ADD, 32'd15, 1'b0, 1'b0, 0, 1'b1, acc, rc, en);
    check("early ready rsp cycle", rc, L1 + 1);
    @(negedge clk);
    check("early ready idle", busy, 1'b0);
    @(posedge clk); #1;

    // Reset during EXEC drops the operation; port 1 accepted right after.
    req_a0 = 32'd3; req_b0 = 32'd3; req_op0 = ALU_ADD; req_valid = 2'b01;
    @(negedge clk);
    check("rst-exec accept", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00; reset = 1'b1;
    @(negedge clk);
    check("rst-exec alu_en", alu_en, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0; t_drop = cyc;
    run_op(1, 32'd100, 32'd1, ALU_SUB, 32'd99, 1'b0, 1'b0, 0, 1'b0, acc, rc, en);
    check("post-reset accept cycle", acc, t_drop);

    // Latency-3 instance: ALU output garbage in EXEC cycles 1-2.
    t3_req_a0 = 32'd5; t3_req_b0 = 32'd7; t3_req_op0 = ALU_ADD; t3_req_valid = 2'b01;
    @(negedge clk);
    check("l3 accept", t3_req_ready, 2'b01);
    check("l3 c0 alu_en", t3_alu_en, 1'b0);
    @(posedge clk); #1;
    t3_req_valid = 2'b00; t3_junk = 1'b1;
    @(negedge clk);
    check("l3 c1 alu_en", t3_alu_en, 1'b1);
    check("l3 c1 alu_a", t3_alu_a, 32'd5);
    @(posedge clk); #1;
    @(negedge clk);
    check("l3 c2 alu_en", t3_alu_en, 1'b1);
    check("l3 c2 rsp_valid", t3_rsp_valid, 2'b00);
    @(posedge clk); #1;
    t3_junk = 1'b0;
    @(negedge clk);
    check("l3 c3 alu_en", t3_alu_en, 1'b1);
    check("l3 c3 rsp_valid", t3_rsp_valid, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    check("l3 c4 rsp_valid", t3_rsp_valid, 2'b01);
    check("l3 c4 result", t3_rsp_result, 32'd12);
    check("l3 c4 neg", t3_rsp_neg, 1'b0);
    check("l3 c4 zero", t3_rsp_zero, 1'b0);
    check("l3 c4 alu_en", t3_alu_en, 1'b0);
    check("l3 c4 alu_b hold", t3_alu_b, 32'd7);
    @(posedge clk); #1;
    t3_rsp_ready = 2'b01;
    @(posedge clk); #1;
    t3_rsp_ready = 2'b00;
    @(negedge clk);
    check("l3 idle", t3_busy, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
